// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity-type constants
// and the parity helper used by the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // data_xor is the XOR-reduction of the payload; odd parity inverts it.
   function automatic logic parity_bit(input logic data_xor, input logic par_typ);
      return data_xor ^ (par_typ == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_hold_buf.sv
// One-entry hold buffer for uart_tx (payload + parity enable + parity type).
// Only instantiated when UART_TX_HOLD_BUF_EN is defined. The transmitter never
// pushes and pops in the same cycle: push needs the buffer empty, pop needs it full.
module uart_tx_hold_buf #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  par_en_i,
   input  logic                  par_typ_i,
   output logic                  full_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  par_en_o,
   output logic                  par_typ_o
);

   logic                  full_q, full_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;

   // Next-state: capture on push, release on pop.
   always_comb begin
      full_d    = full_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      if (push_i) begin
         full_d    = 1'b1;
         data_d    = data_i;
         par_en_d  = par_en_i;
         par_typ_d = par_typ_i;
      end else if (pop_i) begin
         full_d    = 1'b0;
      end
   end

   // Buffer registers with synchronous reset to empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q    <= 1'b0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else begin
         full_q    <= full_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
      end
   end

   assign full_o    = full_q;
   assign data_o    = data_q;
   assign par_en_o  = par_en_q;
   assign par_typ_o = par_typ_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one stop bit. One serial bit per tx_clk cycle; s_data_out is registered.
// Optional feature macro: UART_TX_HOLD_BUF_EN adds a one-entry hold buffer so a
// frame can be accepted while another is on the line.
//
// state  | meaning
// IDLE   | line high, waiting for a frame
// START  | start bit (0) on the line
// DATA   | payload bit cnt_q on the line
// PARITY | parity bit on the line (only when captured par_en=1)
// STOP   | stop bit (1) on the line; may chain directly into START
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  tx_clk,
   input  logic                  res,
   input  logic [DATA_WIDTH-1:0] p_data_in,
   input  logic                  data_valid_in,
   input  logic                  par_en_in,
   input  logic                  par_typ_in,
   output logic                  ready_out,
   output logic                  s_data_out,
   output logic                  busy_out
);

   localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   tx_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  sdata_q, sdata_d;
   logic                  load;

   // Frame source and handshake; the source is the hold buffer when it holds a frame.
   logic                  accept;
   logic                  pending;
   logic [DATA_WIDTH-1:0] src_data;
   logic                  src_par_en;
   logic                  src_par_typ;

`ifdef UART_TX_HOLD_BUF_EN
   logic                  buf_full;
   logic [DATA_WIDTH-1:0] buf_data;
   logic                  buf_par_en;
   logic                  buf_par_typ;
   logic                  buf_push;
   logic                  buf_pop;
   logic                  load_direct;

   assign ready_out   = ~buf_full;
   assign accept      = data_valid_in & ready_out;
   assign pending     = buf_full;
   // Direct load when the line is free for a new frame and nothing is queued.
   assign load_direct = accept & ((state_q == IDLE) | ((state_q == STOP) & ~buf_full));
   assign buf_push    = accept & ~load_direct;
   assign buf_pop     = (state_q == STOP) & buf_full;
   assign src_data    = buf_full ? buf_data    : p_data_in;
   assign src_par_en  = buf_full ? buf_par_en  : par_en_in;
   assign src_par_typ = buf_full ? buf_par_typ : par_typ_in;

   uart_tx_hold_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_hold_buf (
      .clk       (tx_clk),
      .rst       (res),
      .push_i    (buf_push),
      .pop_i     (buf_pop),
      .data_i    (p_data_in),
      .par_en_i  (par_en_in),
      .par_typ_i (par_typ_in),
      .full_o    (buf_full),
      .data_o    (buf_data),
      .par_en_o  (buf_par_en),
      .par_typ_o (buf_par_typ)
   );
`else
   assign ready_out   = (state_q == IDLE) | (state_q == STOP);
   assign accept      = data_valid_in & ready_out;
   assign pending     = 1'b0;
   assign src_data    = p_data_in;
   assign src_par_en  = par_en_in;
   assign src_par_typ = par_typ_in;
`endif

   // Next state, bit counter, frame capture and next serial bit.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      load      = 1'b0;
      sdata_d   = 1'b1;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               load    = 1'b1;
            end
         end
         START: begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               state_d = par_en_q ? PARITY : STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PARITY: begin
            state_d = STOP;
         end
         STOP: begin
            if (pending | accept) begin
               state_d = START;
               load    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load) begin
         data_d    = src_data;
         par_en_d  = src_par_en;
         par_typ_d = src_par_typ;
      end

      // The line value is decided one cycle ahead so the output comes straight from a flop.
      case (state_d)
         START:   sdata_d = 1'b0;
         DATA:    sdata_d = data_q[cnt_d];
         PARITY:  sdata_d = parity_bit(^data_q, par_typ_q);
         default: sdata_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset aborts any frame and returns the line high.
   always_ff @(posedge tx_clk) begin
      if (res) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         sdata_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         sdata_q   <= sdata_d;
      end
   end

   assign s_data_out = sdata_q;
   assign busy_out   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (DATA_WIDTH=8). Expected line patterns are written
// in transmission order: the leftmost bit of each literal is the first bit sent.
module tb_uart_tx;

   logic       tx_clk;
   logic       res;
   logic [7:0] p_data_in;
   logic       data_valid_in;
   logic       par_en_in;
   logic       par_typ_in;
   logic       ready_out;
   logic       s_data_out;
   logic       busy_out;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .tx_clk        (tx_clk),
      .res           (res),
      .p_data_in     (p_data_in),
      .data_valid_in (data_valid_in),
      .par_en_in     (par_en_in),
      .par_typ_in    (par_typ_in),
      .ready_out     (ready_out),
      .s_data_out    (s_data_out),
      .busy_out      (busy_out)
   );

   initial tx_clk = 1'b0;
   always #5 tx_clk = ~tx_clk;

   task automatic tick();
      @(posedge tx_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_sdata"}, s_data_out, 1'b1);
      chk({tag, "_busy"},  busy_out,   1'b0);
      chk({tag, "_ready"}, ready_out,  1'b1);
   endtask

   // Send one frame from idle; exp holds the line bits in send order (MSB first).
   task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                            input logic pt, input logic [10:0] exp, input int len);
      logic exp_rdy;
      p_data_in     = d;
      par_en_in     = pe;
      par_typ_in    = pt;
      data_valid_in = 1'b1;
      tick();
      data_valid_in = 1'b0;
      p_data_in     = ~d;
      par_en_in     = ~pe;
      par_typ_in    = ~pt;
      for (int i = 0; i < len; i++) begin
`ifdef UART_TX_HOLD_BUF_EN
         exp_rdy = 1'b1;
`else
         exp_rdy = (i == len - 1);
`endif
         chk($sformatf("%s_line%0d", tag, i),  s_data_out, exp[10-i]);
         chk($sformatf("%s_busy%0d", tag, i),  busy_out,   1'b1);
         chk($sformatf("%s_ready%0d", tag, i), ready_out,  exp_rdy);
`ifndef UART_TX_HOLD_BUF_EN
         // A valid pulse mid-frame must be ignored entirely.
         data_valid_in = (i == 3);
`endif
         tick();
      end
      data_valid_in = 1'b0;
      chk_idle({tag, "_after"});
   endtask

   initial begin
      logic [19:0] exp20;
      logic        exp_rdy;

      res           = 1'b1;
      p_data_in     = 8'h00;
      data_valid_in = 1'b0;
      par_en_in     = 1'b0;
      par_typ_in    = 1'b0;
      tick();
      tick();
      chk_idle("reset");
      res = 1'b0;
      tick();
      chk_idle("idle");

      run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 11'b01010010101, 11);
      run_frame("a5_odd",  8'hA5, 1'b1, 1'b1, 11'b01010010111, 11);
      run_frame("00_nopar", 8'h00, 1'b0, 1'b0, 11'b00000000010, 10);
      run_frame("3a_even", 8'h3A, 1'b1, 1'b0, 11'b00101110001, 11);
      run_frame("80_odd",  8'h80, 1'b1, 1'b1, 11'b00000000101, 11);

      // Back-to-back: 0x55 then 0x0F (no parity), second held valid until taken.
      exp20         = 20'b0101010101_0111100001;
      p_data_in     = 8'h55;
      par_en_in     = 1'b0;
      par_typ_in    = 1'b0;
      data_valid_in = 1'b1;
      tick();
      p_data_in     = 8'h0F;
      for (int i = 0; i < 20; i++) begin
`ifdef UART_TX_HOLD_BUF_EN
         exp_rdy = (i == 0) || (i >= 10);
`else
         exp_rdy = (i == 9) || (i == 19);
`endif
         chk($sformatf("b2b_line%0d", i),  s_data_out, exp20[19-i]);
         chk($sformatf("b2b_busy%0d", i),  busy_out,   1'b1);
         chk($sformatf("b2b_ready%0d", i), ready_out,  exp_rdy);
         if (i == 10) data_valid_in = 1'b0;
         tick();
      end
      chk_idle("b2b_after");

      // Reset while bit 3 of 0xFF is on the line.
      p_data_in     = 8'hFF;
      par_en_in     = 1'b0;
      data_valid_in = 1'b1;
      tick();
      data_valid_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("abort_line%0d", i), s_data_out, (i == 0) ? 1'b0 : 1'b1);
         tick();
      end
      chk("abort_bit3_busy", busy_out, 1'b1);
      res = 1'b1;
      tick();
      res = 1'b0;
      chk_idle("abort_reset");
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("abort_quiet_busy%0d", i), busy_out,   1'b0);
         chk($sformatf("abort_quiet_line%0d", i), s_data_out, 1'b1);
         tick();
      end
      run_frame("post_abort", 8'h00, 1'b0, 1'b0, 11'b00000000010, 10);

`ifdef UART_TX_HOLD_BUF_EN
      // 0x3C accepted during the START bit of 0xC3 waits in the buffer.
      exp20         = 20'b0110000111_0001111001;
      p_data_in     = 8'hC3;
      par_en_in     = 1'b0;
      par_typ_in    = 1'b0;
      data_valid_in = 1'b1;
      tick();
      p_data_in     = 8'h3C;
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("hold_line%0d", i),  s_data_out, exp20[19-i]);
         chk($sformatf("hold_busy%0d", i),  busy_out,   1'b1);
         chk($sformatf("hold_ready%0d", i), ready_out,  (i == 0) || (i >= 10));
         if (i == 0) data_valid_in = 1'b0;
         tick();
      end
      chk_idle("hold_after");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
